// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx
// Brief    : Pops bytes from a single-clock FIFO and serialises each one as an
//            async frame: start 0, 8 data bits LSB first, optional even parity,
//            stop 1.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        fifo_get,
    output logic        tx,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frames_sent
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_req    = 3'd1;
    localparam logic [2:0] c_st_load   = 3'd2;
    localparam logic [2:0] c_st_start  = 3'd3;
    localparam logic [2:0] c_st_data   = 3'd4;
    localparam logic [2:0] c_st_parity = 3'd5;
    localparam logic [2:0] c_st_stop   = 3'd6;

    localparam logic [7:0] c_baud_last = 8'(CLKS_PER_BIT - 1);
    localparam logic [2:0] c_last_bit  = 3'd7;

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [7:0] r_baud;
    logic [2:0] r_bit;
    logic [7:0] r_shift;
    logic       r_parity;

    logic       w_bit_state;
    logic       w_baud_last;
    logic       w_launch;
    logic [7:0] w_shift_nxt;
    logic       w_tx_nxt;
    logic       w_get_nxt;
    logic       w_busy_nxt;
    logic       w_done_nxt;

    assign w_bit_state = (r_state == c_st_start) || (r_state == c_st_data) ||
                         (r_state == c_st_parity) || (r_state == c_st_stop);
    assign w_baud_last = w_bit_state && (r_baud == c_baud_last);
    assign w_launch    = enable && !fifo_empty;

    // Next-state logic; fifo_empty only matters in IDLE and at the end of STOP.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:   if (w_launch) w_state_nxt = c_st_req;
            c_st_req:    w_state_nxt = c_st_load;
            c_st_load:   w_state_nxt = c_st_start;
            c_st_start:  if (w_baud_last) w_state_nxt = c_st_data;
            c_st_data: begin
                if (w_baud_last && (r_bit == c_last_bit))
                    w_state_nxt = (PARITY_EN != 0) ? c_st_parity : c_st_stop;
            end
            c_st_parity: if (w_baud_last) w_state_nxt = c_st_stop;
            c_st_stop: begin
                if (w_baud_last)
                    w_state_nxt = w_launch ? c_st_req : c_st_idle;
            end
            default:     w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        w_shift_nxt = r_shift;
        if (r_state == c_st_load)
            w_shift_nxt = fifo_data;
        else if ((r_state == c_st_data) && w_baud_last)
            w_shift_nxt = {1'b0, r_shift[7:1]};
    end

    // Outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            c_st_start:  w_tx_nxt = 1'b0;
            c_st_data:   w_tx_nxt = w_shift_nxt[0];
            c_st_parity: w_tx_nxt = r_parity;
            default:     w_tx_nxt = 1'b1;
        endcase
        w_get_nxt  = (w_state_nxt == c_st_req);
        w_busy_nxt = (w_state_nxt != c_st_idle);
        w_done_nxt = (r_state == c_st_stop) && w_baud_last;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= c_st_idle;
            r_baud   <= 8'd0;
            r_bit    <= 3'd0;
            r_shift  <= 8'd0;
            r_parity <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            if (r_state == c_st_load)
                r_parity <= ^fifo_data;
            if (!w_bit_state || w_baud_last)
                r_baud <= 8'd0;
            else
                r_baud <= r_baud + 8'd1;
            if (r_state != c_st_data)
                r_bit <= 3'd0;
            else if (w_baud_last)
                r_bit <= r_bit + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx          <= 1'b1;
            fifo_get    <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frames_sent <= 16'd0;
        end else begin
            tx         <= w_tx_nxt;
            fifo_get   <= w_get_nxt;
            busy       <= w_busy_nxt;
            frame_done <= w_done_nxt;
            if (w_done_nxt)
                frames_sent <= frames_sent + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_uart_tx
// Brief    : Self-checking bench for fifo_uart_tx with a queue-based FIFO model
//            and a frame-level reference for the serial line.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int CPB = 4;
    localparam int PAR = 1;
    localparam int N   = (10 + PAR) * CPB;

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic        enable     = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_data  = 8'd0;
    logic        fifo_get;
    logic        tx;
    logic        busy;
    logic        frame_done;
    logic [15:0] frames_sent;

    logic        push_req  = 1'b0;
    logic [7:0]  push_data = 8'd0;
    logic [7:0]  fifo_q[$];
    int          gets       = 0;
    int          underflows = 0;
    int          cyc        = 0;

    int          n_tests      = 0;
    int          n_fail       = 0;
    int          model_frames = 0;

    fifo_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .PARITY_EN    (PAR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .fifo_get    (fifo_get),
        .tx          (tx),
        .busy        (busy),
        .frame_done  (frame_done),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: data valid the edge after the edge that samples fifo_get.
    always @(posedge clk) begin
        if (fifo_get) begin
            gets <= gets + 1;
            if (fifo_q.size() == 0)
                underflows <= underflows + 1;
            else
                fifo_data <= fifo_q.pop_front();
        end
        if (push_req)
            fifo_q.push_back(push_data);
        fifo_empty <= (fifo_q.size() == 0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Frame slot j: 0 = start, 1..8 = data LSB first, then even parity, then stop.
    function automatic logic exp_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        if (PAR != 0 && j == 9) return (($countones(b) % 2) == 1);
        return 1'b1;
    endfunction

    task automatic push(input logic [7:0] b);
        push_req  = 1'b1;
        push_data = b;
        @(negedge clk);
        push_req  = 1'b0;
    endtask

    task automatic expect_frame(input logic [7:0] b, input int drop_at, input int rst_at,
                                output int start_cyc);
        int waited;
        waited    = 0;
        start_cyc = -1;
        while (tx !== 1'b0 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (tx !== 1'b0) begin
            check("start_timeout", {31'd0, tx}, 32'd0);
            return;
        end
        start_cyc = cyc;
        for (int i = 0; i < N; i++) begin
            if (i == drop_at) enable = 1'b0;
            if (i == rst_at) begin
                #2 reset = 1'b0;
                #1;
                check("rst_tx", {31'd0, tx}, 32'd1);
                check("rst_busy", {31'd0, busy}, 32'd0);
                check("rst_frames", {16'd0, frames_sent}, 32'd0);
                model_frames = 0;
                @(negedge clk);
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            check("tx_bit", {31'd0, tx}, {31'd0, exp_bit(b, i / CPB)});
            check("busy_in_frame", {31'd0, busy}, 32'd1);
            check("done_early", {31'd0, frame_done}, 32'd0);
            @(negedge clk);
        end
        model_frames = (model_frames + 1) & 16'hFFFF;
        check("frame_done", {31'd0, frame_done}, 32'd1);
        check("frames_sent", {16'd0, frames_sent}, model_frames);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, s1, s2, c0, g0, n, drop;
        logic [7:0] bytes[3];

        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_get", {31'd0, fifo_get}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, frame_done}, 32'd0);
        check("reset_frames", {16'd0, frames_sent}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single frame: launch latency, one pop, return to idle.
        enable = 1'b1;
        g0 = gets;
        c0 = cyc;
        push(8'hA5);
        expect_frame(8'hA5, -1, -1, s);
        check("launch_latency", s - c0, 32'd4);
        check("get_once", gets - g0, 32'd1);
        check("idle_after", {31'd0, busy}, 32'd0);

        // Parity bit 1 case.
        push(8'h07);
        expect_frame(8'h07, -1, -1, s);

        // Empty FIFO with enable held.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("empty_get", {31'd0, fifo_get}, 32'd0);
            check("empty_tx", {31'd0, tx}, 32'd1);
            check("empty_busy", {31'd0, busy}, 32'd0);
        end

        // Back-to-back frames from a preloaded FIFO.
        enable = 1'b0;
        push(8'hFF);
        push(8'h00);
        repeat (5) @(negedge clk);
        check("disabled_busy", {31'd0, busy}, 32'd0);
        g0 = gets;
        enable = 1'b1;
        expect_frame(8'hFF, -1, -1, s1);
        check("chain_busy", {31'd0, busy}, 32'd1);
        expect_frame(8'h00, -1, -1, s2);
        check("chain_gap", s2 - s1, N + 2);
        check("chain_gets", gets - g0, 32'd2);
        check("chain_empty", {31'd0, fifo_empty}, 32'd1);

        // Drop enable during data bit 3: frame completes, then block parks.
        push(8'h3C);
        push(8'h55);
        g0 = gets;
        expect_frame(8'h3C, 4 * CPB + 1, -1, s);
        check("parked_busy", {31'd0, busy}, 32'd0);
        repeat (20) @(negedge clk);
        check("parked_gets", gets - g0, 32'd1);
        check("parked_tx", {31'd0, tx}, 32'd1);
        enable = 1'b1;
        expect_frame(8'h55, -1, -1, s);

        // Asynchronous reset mid-data while bit 2 (a zero) is on the line.
        push(8'h81);
        push(8'h6E);
        expect_frame(8'h81, -1, 3 * CPB + 1, s);
        expect_frame(8'h6E, -1, -1, s);

        // Randomised bursts.
        for (int it = 0; it < 12; it++) begin
            n = int'($urandom_range(1, 3));
            for (int k = 0; k < n; k++) begin
                bytes[k] = 8'($urandom);
                push(bytes[k]);
            end
            for (int k = 0; k < n; k++) begin
                drop = (k == n - 1 && ($urandom % 3) == 0) ? int'($urandom_range(0, N - 1)) : -1;
                expect_frame(bytes[k], drop, -1, s);
            end
            enable = 1'b1;
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("no_underflow", underflows, 32'd0);
        check("final_empty", {31'd0, fifo_empty}, 32'd1);
        check("final_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
